johnson_phase_tracker: RTL and testbench
========================================

Name: johnson_phase_tracker

Overview:
Downstream consumer of the parameterized Johnson up/down counter. It samples the counter's Johnson code and checks that the code is legal and that each transition is a legal single step. It decodes the code to a binary phase index and a one-hot phase, reports step direction, and keeps a signed revolution count. Faults (illegal code or skipped phase) are latched until software clears them.

Parameters:
WIDTH, 4, Johnson code width; 2*WIDTH phases; must be >= 2
REV_W, 8, width of the signed revolution counter
IDX_W, $clog2(2*WIDTH), phase index width (derived, not overridable)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
sample_en  input  1  johnson_in is sampled on rising clk when high
johnson_in  input  WIDTH  Johnson code from counter
clear_fault  input  1  clears latched fault, returns to SYNC
phase_idx  output  IDX_W  decoded phase index
phase_onehot  output  2*WIDTH  one-hot of phase_idx; all-zero when phase_valid=0
phase_valid  output  1  tracker locked, outputs meaningful
dir  output  1  last step direction: 1=up, 0=down
step_pulse  output  1  one-cycle pulse per accepted step
rev_count  output  REV_W  signed revolutions, two's complement
rev_pulse  output  1  one-cycle pulse on wrap
fault  output  1  sticky fault flag
fault_code  output  2  00 none, 01 illegal code, 10 skipped phase

Behaviour:
- Reset values (asynchronous, active-high): phase_idx=0, phase_onehot=0, phase_valid=0, dir=1, step_pulse=0, rev_count=0, rev_pulse=0, fault=0, fault_code=00, state=SYNC. Asserting rst mid-operation forces these values immediately.
- Decode (W=WIDTH, code c):
  - If c[W-1]=1 and the ones run contiguous from the MSB (k ones): legal, idx=k-1.
  - If c[W-1]=0 and the ones run contiguous from the LSB (m ones, 0..W-1): legal, idx=2W-1-m.
  - Anything else is illegal. For W=4, the up sequence is 1000,1100,1110,1111,0111,0011,0001,0000 = idx 0..7.
- Latency: all outputs update on the clk edge that samples a code, so they are valid in the following cycle. Pulses last exactly one cycle. With sample_en low, nothing changes except pulses clearing.
- FSM states: SYNC, TRACK, FAULT.
  - SYNC, legal sample: load idx, phase_valid=1, go to TRACK. No step_pulse and no rev change.
  - TRACK, legal sample: delta=(new-old) mod 2W.
    - delta 0: hold, no pulse.
    - delta 1: step up, dir=1, step_pulse. If old=2W-1 and new=0: rev_count+1 and rev_pulse.
    - delta 2W-1: step down, dir=0, step_pulse. If old=0 and new=2W-1: rev_count-1 and rev_pulse.
    - Any other delta: go to FAULT, fault_code=10.
  - Any state, illegal sample: go to FAULT, fault_code=01, phase_valid=0. This includes FAULT itself, where fault_code is overwritten with the latest cause.
  - FAULT: fault=1, phase_valid=0, phase_onehot=0. phase_idx and rev_count hold. Legal samples are ignored.
  - clear_fault in FAULT: go to SYNC, fault=0, fault_code=00. rev_count is preserved.
  - clear_fault outside FAULT: ignored.
- Simultaneous clear_fault and sample_en in FAULT: clear wins and that sample is discarded.
- rev_count wraps modulo 2^REV_W: 127+1 gives -128 and -128-1 gives 127, with no saturation.

Decomposition:
- Package johnson_tracker_pkg holds:
  - the state enum {SYNC, TRACK, FAULT};
  - the fault_code constants FC_NONE, FC_ILLEGAL, FC_SKIP;
  - functions is_legal_johnson and johnson_to_idx, parameterized by width.
- One sub-module, johnson_code_decoder: combinational legality check plus index and one-hot decode, reused by the tracker.

Test Plan:
1. rst pulse, then sample 1000 -> next cycle phase_valid=1, phase_idx=0, phase_onehot=00000001, step_pulse=0, state TRACK.
2. From 1000, sample the full up sequence 1100..0000 then 1000 -> step_pulse on each of the 8 steps with dir=1; on the final step phase_idx=0, rev_pulse=1, rev_count=1.
3. Lock on 1000, sample 0000 -> phase_idx=7, dir=0, rev_count=0xFF (-1), rev_pulse=1. Sample 0000 again -> no step_pulse.
4. Lock on 1100, sample 1111 -> fault=1, fault_code=10, phase_valid=0. Assert clear_fault -> fault=0, state SYNC. Sample 0111 -> phase_idx=4, phase_valid=1.
5. In TRACK, sample 1010 -> fault_code=01. Then assert clear_fault and sample_en with 1000 in the same cycle -> SYNC, sample ignored, phase_valid stays 0.
6. Run up 128 revolutions with REV_W=8 -> rev_count=0x80 (-128). Then assert rst mid-step -> all outputs return to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/johnson_tracker_pkg.sv
// Shared types, fault codes and Johnson-code helpers for the phase tracker.
// Helpers take the code zero-extended to MAX_W bits plus the real code width.
package johnson_tracker_pkg;

    typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_SKIP    = 2'b10;

    localparam int MAX_W = 32;
    typedef logic [MAX_W-1:0] code_t;

    function automatic int count_ones(input code_t code, input int width);
        int ones;
        ones = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width && code[i]) ones++;
        end
        return ones;
    endfunction

    function automatic logic code_msb(input code_t code, input int width);
        logic msb;
        msb = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == width - 1) msb = code[i];
        end
        return msb;
    endfunction

    // A legal code is fully determined by its MSB and its population count,
    // so rebuild that unique candidate and compare it against the input.
    function automatic logic is_legal_johnson(input code_t code, input int width);
        code_t expect_code;
        int    ones;
        logic  msb;
        ones        = count_ones(code, width);
        msb         = code_msb(code, width);
        expect_code = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) expect_code[i] = msb ? (i >= width - ones) : (i < ones);
        end
        return code == expect_code;
    endfunction

    function automatic int johnson_to_idx(input code_t code, input int width);
        int ones;
        ones = count_ones(code, width);
        return code_msb(code, width) ? ones - 1 : 2 * width - 1 - ones;
    endfunction

endpackage

// File: rtl/johnson_code_decoder.sv
// Combinational Johnson code check: legality, binary phase index and one-hot phase.
// idx is only meaningful when legal is high; onehot is all-zero for illegal codes.
module johnson_code_decoder
    import johnson_tracker_pkg::*;
#(
    parameter  int WIDTH  = 4,
    localparam int PHASES = 2 * WIDTH,
    localparam int IDX_W  = $clog2(PHASES)
) (
    input  logic [WIDTH-1:0]  code,
    output logic              legal,
    output logic [IDX_W-1:0]  idx,
    output logic [PHASES-1:0] onehot
);

    code_t code_ext;

    always_comb begin
        code_ext              = '0;
        code_ext[WIDTH-1:0]   = code;
        legal                 = is_legal_johnson(code_ext, WIDTH);
        idx                   = IDX_W'(johnson_to_idx(code_ext, WIDTH));
        onehot                = '0;
        if (legal) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/johnson_phase_tracker.sv
// Tracks a Johnson counter: locks on a legal code, accepts single steps,
// counts signed revolutions and latches illegal-code / skipped-phase faults.
module johnson_phase_tracker
    import johnson_tracker_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int REV_W  = 8,
    localparam int PHASES = 2 * WIDTH,
    localparam int IDX_W  = $clog2(PHASES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic [WIDTH-1:0]  johnson_in,
    input  logic              clear_fault,
    output logic [IDX_W-1:0]  phase_idx,
    output logic [PHASES-1:0] phase_onehot,
    output logic              phase_valid,
    output logic              dir,
    output logic              step_pulse,
    output logic [REV_W-1:0]  rev_count,
    output logic              rev_pulse,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PHASES - 1);

    logic              dec_legal;
    logic [IDX_W-1:0]  dec_idx;
    logic [PHASES-1:0] dec_onehot;

    johnson_code_decoder #(.WIDTH(WIDTH)) u_decoder (
        .code   (johnson_in),
        .legal  (dec_legal),
        .idx    (dec_idx),
        .onehot (dec_onehot)
    );

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic [PHASES-1:0] onehot_nxt;
    logic              valid_nxt, dir_nxt, step_nxt, rev_pulse_nxt, fault_nxt;
    logic [REV_W-1:0]  rev_nxt;
    logic [1:0]        fc_nxt;
    int                delta;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = phase_idx;
        onehot_nxt    = phase_onehot;
        valid_nxt     = phase_valid;
        dir_nxt       = dir;
        step_nxt      = 1'b0;
        rev_nxt       = rev_count;
        rev_pulse_nxt = 1'b0;
        fault_nxt     = fault;
        fc_nxt        = fault_code;
        delta         = (int'(dec_idx) + PHASES - int'(phase_idx)) % PHASES;

        // A clear in FAULT takes priority and swallows any same-cycle sample.
        if (state == FAULT && clear_fault) begin
            state_nxt = SYNC;
            fault_nxt = 1'b0;
            fc_nxt    = FC_NONE;
        end else if (sample_en) begin
            if (!dec_legal) begin
                state_nxt  = FAULT;
                fault_nxt  = 1'b1;
                fc_nxt     = FC_ILLEGAL;
                valid_nxt  = 1'b0;
                onehot_nxt = '0;
            end else begin
                unique case (state)
                    SYNC: begin
                        state_nxt  = TRACK;
                        idx_nxt    = dec_idx;
                        onehot_nxt = dec_onehot;
                        valid_nxt  = 1'b1;
                    end
                    TRACK: begin
                        if (delta == 1) begin
                            idx_nxt    = dec_idx;
                            onehot_nxt = dec_onehot;
                            dir_nxt    = 1'b1;
                            step_nxt   = 1'b1;
                            if (phase_idx == LAST_IDX) begin
                                rev_nxt       = rev_count + REV_W'(1);
                                rev_pulse_nxt = 1'b1;
                            end
                        end else if (delta == PHASES - 1) begin
                            idx_nxt    = dec_idx;
                            onehot_nxt = dec_onehot;
                            dir_nxt    = 1'b0;
                            step_nxt   = 1'b1;
                            if (phase_idx == '0) begin
                                rev_nxt       = rev_count - REV_W'(1);
                                rev_pulse_nxt = 1'b1;
                            end
                        end else if (delta != 0) begin
                            state_nxt  = FAULT;
                            fault_nxt  = 1'b1;
                            fc_nxt     = FC_SKIP;
                            valid_nxt  = 1'b0;
                            onehot_nxt = '0;
                        end
                    end
                    FAULT: ;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SYNC;
            phase_idx    <= '0;
            phase_onehot <= '0;
            phase_valid  <= 1'b0;
            dir          <= 1'b1;
            step_pulse   <= 1'b0;
            rev_count    <= '0;
            rev_pulse    <= 1'b0;
            fault        <= 1'b0;
            fault_code   <= FC_NONE;
        end else begin
            state        <= state_nxt;
            phase_idx    <= idx_nxt;
            phase_onehot <= onehot_nxt;
            phase_valid  <= valid_nxt;
            dir          <= dir_nxt;
            step_pulse   <= step_nxt;
            rev_count    <= rev_nxt;
            rev_pulse    <= rev_pulse_nxt;
            fault        <= fault_nxt;
            fault_code   <= fc_nxt;
        end
    end

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Self-checking bench for johnson_phase_tracker (WIDTH=4, REV_W=8): a directed
// vector table plus hand-written revolution-wrap and asynchronous-reset sequences.
module tb_johnson_phase_tracker;

    logic       clk;
    logic       rst;
    logic       sample_en;
    logic [3:0] johnson_in;
    logic       clear_fault;
    logic [2:0] phase_idx;
    logic [7:0] phase_onehot;
    logic       phase_valid;
    logic       dir;
    logic       step_pulse;
    logic [7:0] rev_count;
    logic       rev_pulse;
    logic       fault;
    logic [1:0] fault_code;

    int checks = 0;
    int errors = 0;

    johnson_phase_tracker #(.WIDTH(4), .REV_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .johnson_in   (johnson_in),
        .clear_fault  (clear_fault),
        .phase_idx    (phase_idx),
        .phase_onehot (phase_onehot),
        .phase_valid  (phase_valid),
        .dir          (dir),
        .step_pulse   (step_pulse),
        .rev_count    (rev_count),
        .rev_pulse    (rev_pulse),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] code;
        logic       clr;
        logic [2:0] idx;
        logic [7:0] oh;
        logic       val;
        logic       dir;
        logic       step;
        logic [7:0] rev;
        logic       rp;
        logic       flt;
        logic [1:0] fc;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic r, input logic en, input logic [3:0] code,
                                input logic clr, input logic [2:0] idx, input logic [7:0] oh,
                                input logic val, input logic d, input logic step,
                                input logic [7:0] rev, input logic rp, input logic flt,
                                input logic [1:0] fc);
        vec_t v;
        v.rst = r; v.en = en; v.code = code; v.clr = clr;
        v.idx = idx; v.oh = oh; v.val = val; v.dir = d; v.step = step;
        v.rev = rev; v.rp = rp; v.flt = flt; v.fc = fc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic r, input logic en, input logic [3:0] code, input logic clr);
        @(negedge clk);
        rst         = r;
        sample_en   = en;
        johnson_in  = code;
        clear_fault = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " idx"},    32'(phase_idx),    32'h0);
        check({tag, " onehot"}, 32'(phase_onehot), 32'h0);
        check({tag, " valid"},  32'(phase_valid),  32'h0);
        check({tag, " dir"},    32'(dir),          32'h1);
        check({tag, " step"},   32'(step_pulse),   32'h0);
        check({tag, " rev"},    32'(rev_count),    32'h0);
        check({tag, " rp"},     32'(rev_pulse),    32'h0);
        check({tag, " fault"},  32'(fault),        32'h0);
        check({tag, " fc"},     32'(fault_code),   32'h0);
    endtask

    logic [3:0] up_codes[8];

    initial begin
        rst = 1'b1; sample_en = 1'b0; johnson_in = 4'b0000; clear_fault = 1'b0;
        up_codes = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};

        //              rst en  code     clr  idx  oh     val dir stp rev    rp flt fc
        // Lock and a full up revolution.
        vecs[0]  = mk(1, 0, 4'b0000, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 2'b00);
        vecs[1]  = mk(0, 1, 4'b1000, 0, 0, 8'h01, 1, 1, 0, 8'h00, 0, 0, 2'b00);
        vecs[2]  = mk(0, 1, 4'b1100, 0, 1, 8'h02, 1, 1, 1, 8'h00, 0, 0, 2'b00);
        vecs[3]  = mk(0, 1, 4'b1110, 0, 2, 8'h04, 1, 1, 1, 8'h00, 0, 0, 2'b00);
        vecs[4]  = mk(0, 1, 4'b1111, 0, 3, 8'h08, 1, 1, 1, 8'h00, 0, 0, 2'b00);
        vecs[5]  = mk(0, 1, 4'b0111, 0, 4, 8'h10, 1, 1, 1, 8'h00, 0, 0, 2'b00);
        vecs[6]  = mk(0, 1, 4'b0011, 0, 5, 8'h20, 1, 1, 1, 8'h00, 0, 0, 2'b00);
        vecs[7]  = mk(0, 1, 4'b0001, 0, 6, 8'h40, 1, 1, 1, 8'h00, 0, 0, 2'b00);
        vecs[8]  = mk(0, 1, 4'b0000, 0, 7, 8'h80, 1, 1, 1, 8'h00, 0, 0, 2'b00);
        vecs[9]  = mk(0, 1, 4'b1000, 0, 0, 8'h01, 1, 1, 1, 8'h01, 1, 0, 2'b00);
        vecs[10] = mk(0, 0, 4'b1100, 0, 0, 8'h01, 1, 1, 0, 8'h01, 0, 0, 2'b00);
        // Down wrap from phase 0, then a repeated code.
        vecs[11] = mk(1, 0, 4'b0000, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 2'b00);
        vecs[12] = mk(0, 1, 4'b1000, 0, 0, 8'h01, 1, 1, 0, 8'h00, 0, 0, 2'b00);
        vecs[13] = mk(0, 1, 4'b0000, 0, 7, 8'h80, 1, 0, 1, 8'hFF, 1, 0, 2'b00);
        vecs[14] = mk(0, 1, 4'b0000, 0, 7, 8'h80, 1, 0, 0, 8'hFF, 0, 0, 2'b00);
        // Skipped phase, legal sample ignored in FAULT, clear, relock.
        vecs[15] = mk(1, 0, 4'b0000, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 2'b00);
        vecs[16] = mk(0, 1, 4'b1100, 0, 1, 8'h02, 1, 1, 0, 8'h00, 0, 0, 2'b00);
        vecs[17] = mk(0, 1, 4'b1111, 0, 1, 8'h00, 0, 1, 0, 8'h00, 0, 1, 2'b10);
        vecs[18] = mk(0, 1, 4'b1000, 0, 1, 8'h00, 0, 1, 0, 8'h00, 0, 1, 2'b10);
        vecs[19] = mk(0, 0, 4'b0000, 1, 1, 8'h00, 0, 1, 0, 8'h00, 0, 0, 2'b00);
        vecs[20] = mk(0, 1, 4'b0111, 0, 4, 8'h10, 1, 1, 0, 8'h00, 0, 0, 2'b00);
        // Illegal code, clear with simultaneous sample, ignored clear in TRACK.
        vecs[21] = mk(0, 1, 4'b1010, 0, 4, 8'h00, 0, 1, 0, 8'h00, 0, 1, 2'b01);
        vecs[22] = mk(0, 1, 4'b1000, 1, 4, 8'h00, 0, 1, 0, 8'h00, 0, 0, 2'b00);
        vecs[23] = mk(0, 1, 4'b1000, 0, 0, 8'h01, 1, 1, 0, 8'h00, 0, 0, 2'b00);
        vecs[24] = mk(0, 0, 4'b1000, 1, 0, 8'h01, 1, 1, 0, 8'h00, 0, 0, 2'b00);
        // rev_count survives a fault and its clear.
        vecs[25] = mk(0, 1, 4'b0000, 0, 7, 8'h80, 1, 0, 1, 8'hFF, 1, 0, 2'b00);
        vecs[26] = mk(0, 1, 4'b1010, 0, 7, 8'h00, 0, 0, 0, 8'hFF, 0, 1, 2'b01);
        vecs[27] = mk(0, 1, 4'b1100, 0, 7, 8'h00, 0, 0, 0, 8'hFF, 0, 1, 2'b01);
        vecs[28] = mk(0, 0, 4'b0000, 1, 7, 8'h00, 0, 0, 0, 8'hFF, 0, 0, 2'b00);
        vecs[29] = mk(0, 1, 4'b0011, 0, 5, 8'h20, 1, 0, 0, 8'hFF, 0, 0, 2'b00);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].code, vecs[i].clr);
            check($sformatf("v%0d idx", i),    32'(phase_idx),    32'(vecs[i].idx));
            check($sformatf("v%0d onehot", i), 32'(phase_onehot), 32'(vecs[i].oh));
            check($sformatf("v%0d valid", i),  32'(phase_valid),  32'(vecs[i].val));
            check($sformatf("v%0d dir", i),    32'(dir),          32'(vecs[i].dir));
            check($sformatf("v%0d step", i),   32'(step_pulse),   32'(vecs[i].step));
            check($sformatf("v%0d rev", i),    32'(rev_count),    32'(vecs[i].rev));
            check($sformatf("v%0d rp", i),     32'(rev_pulse),    32'(vecs[i].rp));
            check($sformatf("v%0d fault", i),  32'(fault),        32'(vecs[i].flt));
            check($sformatf("v%0d fc", i),     32'(fault_code),   32'(vecs[i].fc));
        end

        // 128 up revolutions: +127 then wrap to -128.
        drive(1, 0, 4'b0000, 0);
        check_reset_values("rev_rst");
        drive(0, 1, 4'b1000, 0);
        for (int r = 0; r < 128; r++) begin
            for (int s = 1; s <= 8; s++) begin
                drive(0, 1, up_codes[s % 8], 0);
            end
            if (r == 126) check("rev 127", 32'(rev_count), 32'h7F);
        end
        check("rev 128 count", 32'(rev_count), 32'h80);
        check("rev 128 pulse", 32'(rev_pulse), 32'h1);
        check("rev 128 idx",   32'(phase_idx), 32'h0);
        drive(0, 0, 4'b0000, 0);
        check("rev idle pulse", 32'(rev_pulse),  32'h0);
        check("rev idle step",  32'(step_pulse), 32'h0);
        drive(0, 1, 4'b0000, 0);
        check("rev -129 count", 32'(rev_count), 32'h7F);
        check("rev -129 dir",   32'(dir),       32'h0);
        drive(0, 1, 4'b1000, 0);
        check("rev back count", 32'(rev_count), 32'h80);

        // Asynchronous reset mid-step while clk is high.
        drive(0, 1, 4'b1100, 0);
        check("pre_rst step", 32'(step_pulse), 32'h1);
        check("pre_rst idx",  32'(phase_idx),  32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async clk high", 32'(clk), 32'h1);
        check_reset_values("async_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
